// File: rtl/round_robin_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: controller state encoding,
// default sizing and a small modulo-increment helper for the priority pointer.
package round_robin_arbiter_pkg;

  localparam int DEF_NREQ  = 16;
  localparam int DEF_IDX_W = 4;

  // Two-state controller kept as plain constants so older tools can consume it.
  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t BUSY = 1'b1;

  // Advance an index by one, wrapping back to zero at the requester count.
  function automatic int wrap_inc(input int value, input int limit);
    return (value + 1 >= limit) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/round_robin_arbiter_prio_search.sv
// Rotating priority search: finds the first asserted request starting at the
// pointer position and wrapping through the top of the vector back to zero.
module rr_prio_search #(
  parameter int NREQ  = 16,
  parameter int IDX_W = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int                pos;

  // Rotate the request vector so the pointer lands on bit 0, take the lowest set bit, then undo the rotation.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    dbl   = {req, req};
    rot   = NREQ'(dbl >> ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        pos   = int'(ptr) + k;
        if (pos >= NREQ) begin
          pos = pos - NREQ;
        end
        idx = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with registered grant handshake. A grant is held until
// acknowledged; on acknowledge the pointer moves just past the granted
// requester and the next winner is presented on the following cycle.
module round_robin_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             gnt_ack,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [IDX_W-1:0] ptr_idx
);

  state_t           state;
  logic [IDX_W-1:0] search_ptr;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  // Search from the pointer the arbiter will hold after this edge, so an acknowledged grant is followed immediately by the next one.
  always_comb begin
    search_ptr = ptr_idx;
    if (state == BUSY && gnt_ack) begin
      search_ptr = IDX_W'(wrap_inc(int'(gnt_idx), NREQ));
    end
  end

  rr_prio_search #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_search (
    .req   (req),
    .ptr   (search_ptr),
    .found (win_found),
    .idx   (win_idx)
  );

  // Grant controller: present a winner from IDLE, hold it while BUSY, and on acknowledge either chain to the next winner or fall back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      ptr_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state     <= BUSY;
            gnt_valid <= 1'b1;
            gnt_idx   <= win_idx;
          end else begin
            gnt_valid <= 1'b0;
          end
        end
        BUSY: begin
          if (gnt_ack) begin
            ptr_idx <= search_ptr;
            if (win_found) begin
              gnt_idx <= win_idx;
            end else begin
              state     <= IDLE;
              gnt_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for the round-robin arbiter with hand-computed expectations.
module tb_round_robin_arbiter;
  import round_robin_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        gnt_ack;
  logic        gnt_valid;
  logic [3:0]  gnt_idx;
  logic [3:0]  ptr_idx;

  int check_count;
  int error_count;

  round_robin_arbiter #(
    .NREQ  (DEF_NREQ),
    .IDX_W (DEF_IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt_ack   (gnt_ack),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .ptr_idx   (ptr_idx)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, let one rising edge consume them, then settle past the edge.
  task automatic applyStimulus(input logic [15:0] r, input logic a, input logic rs);
    req     = r;
    gnt_ack = a;
    rst     = rs;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expectation and tally the result.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Checks all three outputs at once.
  task automatic checkAll(input string tag, input logic v, input logic [3:0] g, input logic [3:0] p);
    checkOutput({tag, ".valid"}, 32'(gnt_valid), 32'(v));
    checkOutput({tag, ".idx"},   32'(gnt_idx),   32'(g));
    checkOutput({tag, ".ptr"},   32'(ptr_idx),   32'(p));
  endtask

  // Directed scenario sequence.
  initial begin
    check_count = 0;
    error_count = 0;
    req         = '0;
    gnt_ack     = 1'b0;
    rst         = 1'b1;

    // Reset state
    applyStimulus(16'h0000, 1'b0, 1'b1);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkAll("reset", 1'b0, 4'd0, 4'd0);

    // No requests for ten cycles
    for (int i = 0; i < 10; i++) begin
      applyStimulus(16'h0000, 1'b0, 1'b0);
      checkOutput("idle.valid", 32'(gnt_valid), 32'd0);
      checkOutput("idle.ptr",   32'(ptr_idx),   32'd0);
    end

    // Single requester 0, ack one cycle after each grant
    applyStimulus(16'h0001, 1'b0, 1'b0);
    checkAll("solo.first", 1'b1, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h0001, 1'b1, 1'b0);
      checkAll("solo.acked", 1'b1, 4'd0, 4'd1);
      applyStimulus(16'h0001, 1'b0, 1'b0);
      checkAll("solo.hold", 1'b1, 4'd0, 4'd1);
    end
    applyStimulus(16'h0000, 1'b1, 1'b0);
    checkAll("solo.drain", 1'b0, 4'd0, 4'd1);

    // All requesting with continuous ack: one grant per cycle, wrapping 15 -> 0
    applyStimulus(16'h0000, 1'b0, 1'b1);
    for (int k = 0; k < 18; k++) begin
      applyStimulus(16'hFFFF, 1'b1, 1'b0);
      checkAll("all", 1'b1, 4'(k % 16), 4'(k % 16));
    end
    applyStimulus(16'h0000, 1'b1, 1'b0);
    checkAll("all.drain", 1'b0, 4'd1, 4'd2);

    // Ack while nothing is presented must not move the pointer
    for (int i = 0; i < 2; i++) begin
      applyStimulus(16'h0000, 1'b1, 1'b0);
      checkAll("stray_ack", 1'b0, 4'd1, 4'd2);
    end

    // Grant 13, then pointer 14 with req 0009 wraps to 0, then 3, then 0
    applyStimulus(16'h2000, 1'b0, 1'b0);
    checkAll("wrap.g13", 1'b1, 4'd13, 4'd2);
    applyStimulus(16'h0009, 1'b1, 1'b0);
    checkAll("wrap.g0", 1'b1, 4'd0, 4'd14);
    applyStimulus(16'h0009, 1'b1, 1'b0);
    checkAll("wrap.g3", 1'b1, 4'd3, 4'd1);
    applyStimulus(16'h0009, 1'b1, 1'b0);
    checkAll("wrap.g0b", 1'b1, 4'd0, 4'd4);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    checkAll("wrap.drain", 1'b0, 4'd0, 4'd1);

    // Grant 5 held stable while its request drops and others change
    applyStimulus(16'h0020, 1'b0, 1'b0);
    checkAll("hold.g5", 1'b1, 4'd5, 4'd1);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkAll("hold.c1", 1'b1, 4'd5, 4'd1);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkAll("hold.c2", 1'b1, 4'd5, 4'd1);
    applyStimulus(16'h0810, 1'b0, 1'b0);
    checkAll("hold.c3", 1'b1, 4'd5, 4'd1);
    applyStimulus(16'h0810, 1'b0, 1'b0);
    checkAll("hold.c4", 1'b1, 4'd5, 4'd1);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    checkAll("hold.ack", 1'b0, 4'd5, 4'd6);

    // Reach grant 9 with pointer 9, then reset mid-grant
    applyStimulus(16'h0100, 1'b0, 1'b0);
    checkAll("rstbusy.g8", 1'b1, 4'd8, 4'd6);
    applyStimulus(16'h0200, 1'b1, 1'b0);
    checkAll("rstbusy.g9", 1'b1, 4'd9, 4'd9);
    applyStimulus(16'h0200, 1'b0, 1'b1);
    checkAll("rstbusy.rst", 1'b0, 4'd0, 4'd0);

    // First grant after reset searches from index 0
    applyStimulus(16'h0300, 1'b0, 1'b0);
    checkAll("postrst.g8", 1'b1, 4'd8, 4'd0);
    applyStimulus(16'h0300, 1'b1, 1'b0);
    checkAll("postrst.g9", 1'b1, 4'd9, 4'd9);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
